// File: rtl/jk_bank_pkg.sv
// rtl/jk_bank_pkg.sv - shared mode encodings for the JK register bank
package jk_bank_pkg;

  // Global next-state function selected by MODE
  typedef enum logic [1:0] {
    MODE_JK    = 2'd0,
    MODE_D     = 2'd1,
    MODE_T     = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  // True when the given raw MODE value selects the counter
  function automatic logic is_count_mode(input logic [1:0] mode);
    return mode_e'(mode) == MODE_COUNT;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single state bit with sync reset, clear/set override and enable
module jk_cell
  import jk_bank_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic set,
  input  logic clr,
  input  logic next_bit,
  input  logic reset_bit,
  output logic q
);

  // Reset beats clear, clear beats set, forced bits ignore the enable
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= reset_bit;
    end else if (clr) begin
      q <= 1'b0;
    end else if (set) begin
      q <= 1'b1;
    end else if (ce) begin
      q <= next_bit;
    end
  end

endmodule

// File: rtl/jk_register_bank.sv
// rtl/jk_register_bank.sv - bank of JK flops with JK/D/T/counter modes and terminal count pulse
module jk_register_bank
  import jk_bank_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               NEG_EDGE    = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] SET,
  input  logic [WIDTH-1:0] CLR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             TC
);

  // Every register in the bank updates on the posedge of this clock, so the
  // falling-edge variant is just the inverted input clock.
  logic clk_int;
  assign clk_int = NEG_EDGE ? ~CLK : CLK;

  logic [WIDTH-1:0] next_q;
  logic             up;
  logic             down;
  logic             wrap;
  logic             tc_next;

  // Mode decode: candidate next state for bits not forced by SET/CLR
  always_comb begin
    next_q = Q;
    wrap   = 1'b0;
    up     = J[0] & ~K[0];
    down   = ~J[0] & K[0];
    case (mode_e'(MODE))
      MODE_JK: next_q = (J & ~Q) | (~K & Q);
      MODE_D:  next_q = J;
      MODE_T:  next_q = Q ^ J;
      MODE_COUNT: begin
        if (up) begin
          next_q = Q + WIDTH'(1);
          wrap   = &Q;
        end else if (down) begin
          next_q = Q - WIDTH'(1);
          wrap   = ~|Q;
        end
      end
      default: next_q = Q;
    endcase
  end

  // A wrap only counts as terminal when no bit is being forced
  always_comb begin
    tc_next = CE & is_count_mode(MODE) & ~|SET & ~|CLR & wrap;
  end

  // Terminal-count pulse, one cycle after the wrapping edge
  always_ff @(posedge clk_int) begin
    if (RST) begin
      TC <= 1'b0;
    end else begin
      TC <= tc_next;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk       (clk_int),
      .rst       (RST),
      .ce        (CE),
      .set       (SET[i]),
      .clr       (CLR[i]),
      .next_bit  (next_q[i]),
      .reset_bit (RESET_VALUE[i]),
      .q         (Q[i])
    );
  end

  assign QN = ~Q;

endmodule

// File: tb/tb_jk_register_bank.sv
// tb/tb_jk_register_bank.sv - randomized and directed self-checking bench for jk_register_bank
module tb_jk_register_bank;

  localparam int W = 4;

  logic         CLK;
  logic         RST;
  logic         CE;
  logic [1:0]   MODE;
  logic [W-1:0] J;
  logic [W-1:0] K;
  logic [W-1:0] SET;
  logic [W-1:0] CLR;
  logic [W-1:0] Q;
  logic [W-1:0] QN;
  logic         TC;

  int n_tests = 0;
  int n_fail  = 0;

  int m_q  = 0;
  int m_tc = 0;
  int nx_q;
  int nx_tc;

  jk_register_bank #(
    .WIDTH       (W),
    .RESET_VALUE (4'h0),
    .NEG_EDGE    (1'b1)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .CE   (CE),
    .MODE (MODE),
    .J    (J),
    .K    (K),
    .SET  (SET),
    .CLR  (CLR),
    .Q    (Q),
    .QN   (QN),
    .TC   (TC)
  );

  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: what the bank should hold after the next falling edge
  task automatic model_predict();
    int cand;
    int v;
    bit wrapped;
    wrapped = 0;
    cand = m_q;
    if (MODE == 2'd0) begin
      for (int i = 0; i < W; i++) begin
        case ({J[i], K[i]})
          2'b01:   cand = cand & ~(1 << i);
          2'b10:   cand = cand | (1 << i);
          2'b11:   cand = cand ^ (1 << i);
          default: ;
        endcase
      end
    end else if (MODE == 2'd1) begin
      cand = int'(J);
    end else if (MODE == 2'd2) begin
      cand = m_q ^ int'(J);
    end else begin
      v = m_q;
      if (J[0] && !K[0]) v = v + 1;
      if (!J[0] && K[0]) v = v - 1;
      wrapped = (v > 15) || (v < 0);
      cand = (v + 16) % 16;
    end
    if (!CE) cand = m_q;
    for (int i = 0; i < W; i++) begin
      if (CLR[i])      cand = cand & ~(1 << i);
      else if (SET[i]) cand = cand | (1 << i);
    end
    nx_tc = (CE && MODE == 2'd3 && SET == 0 && CLR == 0 && wrapped) ? 1 : 0;
    nx_q  = cand;
    if (RST) begin
      nx_q  = 0;
      nx_tc = 0;
    end
  endtask

  // Drive one cycle of inputs, clock the falling edge, compare with the model
  task automatic apply(input logic rst, input logic ce, input logic [1:0] mode,
                       input logic [W-1:0] j, input logic [W-1:0] k,
                       input logic [W-1:0] set, input logic [W-1:0] clr, input string tag);
    RST = rst; CE = ce; MODE = mode; J = j; K = k; SET = set; CLR = clr;
    #1;
    model_predict();
    @(negedge CLK);
    #1;
    m_q  = nx_q;
    m_tc = nx_tc;
    check({tag, ".q"},  32'(Q),  32'(m_q));
    check({tag, ".qn"}, 32'(QN), 32'(~m_q & 15));
    check({tag, ".tc"}, 32'(TC), 32'(m_tc));
  endtask

  initial begin
    RST = 1'b0; CE = 1'b0; MODE = 2'd0; J = '0; K = '0; SET = '0; CLR = '0;
    @(posedge CLK);

    apply(1'b1, 1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), "reset");
    check("reset_q", 32'(Q), 32'h0);
    check("reset_qn", 32'(QN), 32'hF);
    check("reset_tc", 32'(TC), 32'h0);

    apply(1'b0, 1'b1, 2'd1, 4'h9, 4'h0, 4'h0, 4'h0, "load9");
    apply(1'b1, 1'b1, 2'd3, 4'h1, 4'h0, 4'h0, 4'h0, "reset_mid");
    check("reset_mid_q", 32'(Q), 32'h0);

    apply(1'b0, 1'b1, 2'd1, 4'h5, 4'h0, 4'h0, 4'h0, "load5");
    apply(1'b0, 1'b1, 2'd0, 4'h3, 4'h9, 4'h0, 4'h0, "jk");
    check("jk_q", 32'(Q), 32'h6);
    apply(1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 4'h0, 4'h0, "jk_tog");
    check("jk_tog_q", 32'(Q), 32'h9);

    apply(1'b0, 1'b1, 2'd1, 4'hA, 4'h0, 4'h0, 4'h0, "d");
    check("d_q", 32'(Q), 32'hA);
    apply(1'b0, 1'b1, 2'd2, 4'h3, 4'h0, 4'h0, 4'h0, "t");
    check("t_q", 32'(Q), 32'h9);
    apply(1'b0, 1'b0, 2'd2, 4'hF, 4'h0, 4'h0, 4'h0, "ce_hold");
    check("ce_hold_q", 32'(Q), 32'h9);

    apply(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0, 4'h0, "load0");
    apply(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'hF, 4'h1, "prio");
    check("prio_q", 32'(Q), 32'hE);
    apply(1'b0, 1'b1, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, "prio_hold");
    check("prio_hold_q", 32'(Q), 32'hE);

    apply(1'b0, 1'b1, 2'd3, 4'h1, 4'h0, 4'h0, 4'h0, "up1");
    check("up1_q", 32'(Q), 32'hF);
    check("up1_tc", 32'(TC), 32'h0);
    apply(1'b0, 1'b1, 2'd3, 4'h1, 4'h0, 4'h0, 4'h0, "up2");
    check("up2_q", 32'(Q), 32'h0);
    check("up2_tc", 32'(TC), 32'h1);
    apply(1'b0, 1'b1, 2'd3, 4'h1, 4'h0, 4'h0, 4'h0, "up3");
    check("up3_tc", 32'(TC), 32'h0);

    apply(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0, 4'h0, "load0b");
    apply(1'b0, 1'b1, 2'd3, 4'h0, 4'h1, 4'h0, 4'h0, "down");
    check("down_q", 32'(Q), 32'hF);
    check("down_tc", 32'(TC), 32'h1);
    apply(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0, 4'h0, "load0c");
    apply(1'b0, 1'b1, 2'd3, 4'h0, 4'h1, 4'h1, 4'h0, "down_set");
    check("down_set_q", 32'(Q), 32'hF);
    check("down_set_tc", 32'(TC), 32'h0);
    apply(1'b0, 1'b1, 2'd3, 4'hF, 4'hF, 4'h0, 4'h0, "cnt_hold");
    check("cnt_hold_q", 32'(Q), 32'hF);

    for (int n = 0; n < 400; n++) begin
      apply(($urandom_range(0, 15) == 0),
            ($urandom_range(0, 7) != 0),
            2'($urandom),
            4'($urandom), 4'($urandom),
            4'($urandom & $urandom & $urandom),
            4'($urandom & $urandom & $urandom & $urandom),
            "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
